// File: rtl/music_box_pkg.sv
// Shared state codes and widths for the music box sequencer
// and the MusicBoxState_* modules it drives.
package music_box_pkg;

  localparam int NUM_STATES = 5;
  localparam int STATE_W    = 5;

  typedef enum logic [STATE_W-1:0] {
    ST_DO_NOTHING     = 5'd0,
    ST_PLAY_SONG0     = 5'd1,
    ST_PLAY_SONG1     = 5'd2,
    ST_RECORD_SONG    = 5'd3,
    ST_PLAY_RECORDING = 5'd4
  } state_t;

endpackage

// File: rtl/music_box_sync_edge.sv
// Multi-flop synchronizer with registered level and rising-edge outputs.
// Both outputs sit one flop past the synchronizer chain.
module music_box_sync_edge #(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  prev_q;
  logic [WIDTH-1:0]                  rise_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= '0;
      rise_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign level = prev_q;
  assign rise  = rise_q;

endmodule

// File: rtl/music_box_state_controller.sv
// Central sequencer: picks an activity from the buttons, waits for its
// owner to complete, abort or time out, then returns to DoNothing.
module music_box_state_controller
  import music_box_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS    = 4,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
  input  logic                   clock_50Mhz,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] buttonPress,
  input  logic [4:0]             stateComplete,
  output logic [4:0]             currentState,
  output logic                   stateChangeStrobe,
  output logic                   timeoutFlag,
  output logic [31:0]            debugString
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [NUM_BUTTONS-1:0] btn_level;
  logic [NUM_BUTTONS-1:0] btn_rise;
  logic [4:0]             cmp_level;
  logic [4:0]             cmp_rise;

  music_box_sync_edge #(
    .WIDTH       (NUM_BUTTONS),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_btn_sync (
    .clk_i (clock_50Mhz),
    .rst_i (reset),
    .din_i (buttonPress),
    .level (btn_level),
    .rise  (btn_rise)
  );

  music_box_sync_edge #(
    .WIDTH       (5),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_cmp_sync (
    .clk_i (clock_50Mhz),
    .rst_i (reset),
    .din_i (stateComplete),
    .level (cmp_level),
    .rise  (cmp_rise)
  );

  logic unused_sync;
  assign unused_sync = ^{btn_level, cmp_rise, cmp_level[0]};

  state_t            state_q;
  logic              armed_q;
  logic              timeout_q;
  logic              strobe_q;
  logic [WD_W-1:0]   wd_q;

  logic              btn_any;
  logic [STATE_W-1:0] btn_state;
  logic [31:0]       btn_ext;
  logic [31:0]       cmp_ext;
  logic              btn_own;
  logic              cmp_cur;

  // Descending scan so the lowest-index rising button wins.
  always_comb begin
    btn_state = '0;
    for (int k = NUM_BUTTONS - 1; k >= 0; k--) begin
      if (btn_rise[k]) btn_state = STATE_W'(k + 1);
    end
  end

  assign btn_any = |btn_rise;
  assign btn_ext = 32'({btn_rise, 1'b0});
  assign cmp_ext = 32'(cmp_level);
  assign btn_own = btn_ext[state_q];
  assign cmp_cur = cmp_ext[state_q];

  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      state_q   <= ST_DO_NOTHING;
      armed_q   <= 1'b0;
      timeout_q <= 1'b0;
      strobe_q  <= 1'b0;
      wd_q      <= '0;
    end else begin
      strobe_q <= 1'b0;
      case (state_q)
        ST_DO_NOTHING: begin
          if (btn_any) begin
            state_q   <= state_t'(btn_state);
            armed_q   <= 1'b0;
            timeout_q <= 1'b0;
            wd_q      <= '0;
            strobe_q  <= 1'b1;
          end
        end
        ST_PLAY_SONG0,
        ST_PLAY_SONG1,
        ST_RECORD_SONG,
        ST_PLAY_RECORDING: begin
          if (!armed_q && !cmp_cur) armed_q <= 1'b1;
          if (wd_q != '1) wd_q <= wd_q + 1'b1;
          if (armed_q && cmp_cur) begin
            state_q  <= ST_DO_NOTHING;
            strobe_q <= 1'b1;
          end else if (btn_own) begin
            state_q  <= ST_DO_NOTHING;
            strobe_q <= 1'b1;
          end else if (wd_q == WD_LAST) begin
            state_q   <= ST_DO_NOTHING;
            timeout_q <= 1'b1;
            strobe_q  <= 1'b1;
          end
        end
        default: begin
          state_q  <= ST_DO_NOTHING;
          strobe_q <= 1'b1;
        end
      endcase
    end
  end

  assign currentState      = state_q;
  assign stateChangeStrobe = strobe_q;
  assign timeoutFlag       = timeout_q;
  assign debugString       = {state_q, armed_q, timeout_q, 25'(wd_q)};

endmodule

// File: tb/tb_music_box_state_controller.sv
// Directed plus random stimulus against a history-based
// behavioural model of the sequencer.
module tb_music_box_state_controller;

  localparam int NB   = 4;
  localparam int TOUT = 1000;
  localparam int LAT  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  btn;
  logic [4:0]  sc;
  logic [4:0]  cur;
  logic        stb;
  logic        tfl;
  logic [31:0] dbg;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  music_box_state_controller #(
    .NUM_BUTTONS    (NB),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .clock_50Mhz       (clk),
    .reset             (rst),
    .buttonPress       (btn),
    .stateComplete     (sc),
    .currentState      (cur),
    .stateChangeStrobe (stb),
    .timeoutFlag       (tfl),
    .debugString       (dbg)
  );

  always #10 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: the sequencer sees raw inputs LAT edges late.
  int         m_st;
  bit         m_armed;
  bit         m_tfl;
  bit         m_stb;
  int         m_el;
  logic [3:0] bh [LAT+1];
  logic [4:0] ch [LAT+1];

  always @(posedge clk) begin
    logic [3:0] r;
    logic [4:0] cl;
    if (rst) begin
      m_st = 0; m_armed = 0; m_tfl = 0; m_stb = 0; m_el = 0;
      for (int k = 0; k <= LAT; k++) begin
        bh[k] = '0;
        ch[k] = '0;
      end
    end else begin
      r  = bh[LAT-1] & ~bh[LAT];
      cl = ch[LAT-1];
      m_stb = 0;
      if (m_st == 0) begin
        for (int k = NB - 1; k >= 0; k--) begin
          if (r[k]) begin
            m_st = k + 1; m_armed = 0; m_el = 0;
            m_tfl = 0; m_stb = 1;
          end
        end
      end else begin
        int  s;
        bit  a;
        s = m_st;
        a = m_armed;
        if (!a && !cl[s]) m_armed = 1;
        if (a && cl[s]) begin
          m_st = 0; m_stb = 1;
        end else if (r[s-1]) begin
          m_st = 0; m_stb = 1;
        end else if (m_el == TOUT - 1) begin
          m_st = 0; m_stb = 1; m_tfl = 1;
        end
        m_el++;
      end
      for (int k = LAT; k > 0; k--) begin
        bh[k] = bh[k-1];
        ch[k] = ch[k-1];
      end
      bh[0] = btn;
      ch[0] = sc;
    end
  end

  always @(negedge clk) begin
    logic [31:0] ed;
    if (chk_en) begin
      ed = {5'(m_st), m_armed, m_tfl, 25'(m_el)};
      chk("state", 32'(cur), 32'(m_st));
      chk("strobe", 32'(stb), 32'(m_stb));
      chk("timeout", 32'(tfl), 32'(m_tfl));
      chk("debug", dbg, ed);
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(int k, int n);
    btn[k] = 1'b1;
    cyc(n);
    btn[k] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    btn = '0;
    sc  = '0;
    @(posedge clk);
    chk_en = 1'b1;
    cyc(3);
    chk("reset_debug", dbg, 32'h0);
    rst = 1'b0;
    cyc(5);

    // Stale completion flag present at entry to state 1.
    sc = 5'b00010;
    btn[0] = 1'b1;
    cyc(10);
    chk("enter_s1", 32'(cur), 32'd1);
    cyc(890);
    btn[0] = 1'b0;
    chk("held_s1", 32'(cur), 32'd1);
    sc[1] = 1'b0;
    cyc(5);
    sc[1] = 1'b1;
    cyc(3);
    chk("pre_done_s1", 32'(cur), 32'd1);
    cyc(5);
    chk("done_s1", 32'(cur), 32'd0);
    sc = '0;
    cyc(5);

    // Simultaneous rises, then foreign and own button.
    btn = 4'b1010;
    cyc(5);
    btn = '0;
    cyc(10);
    chk("lowest_wins", 32'(cur), 32'd2);
    press(3, 5);
    cyc(10);
    chk("other_ignored", 32'(cur), 32'd2);
    press(1, 5);
    cyc(10);
    chk("abort_s2", 32'(cur), 32'd0);

    // Watchdog expiry in state 3.
    press(2, 5);
    cyc(TOUT + 10);
    chk("timeout_state", 32'(cur), 32'd0);
    chk("timeout_flag", 32'(tfl), 32'd1);
    press(0, 5);
    cyc(5);
    chk("reenter_s1", 32'(cur), 32'd1);
    chk("reenter_tflag", 32'(tfl), 32'd0);
    sc[1] = 1'b1;
    cyc(10);
    sc = '0;
    cyc(5);

    // Reset during state 4 together with its completion.
    press(3, 5);
    cyc(10);
    sc[4] = 1'b1;
    rst = 1'b1;
    cyc(1);
    chk("rst_mid_state", 32'(cur), 32'd0);
    chk("rst_mid_strobe", 32'(stb), 32'd0);
    rst = 1'b0;
    sc = '0;
    cyc(10);

    // Random phase.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) btn = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) sc = 5'($urandom_range(0, 31));
      rst = ($urandom_range(0, 599) == 0);
      cyc(1);
    end
    rst = 1'b0;
    btn = '0;
    cyc(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
